// File: rtl/stage_mm.sv
// stage_mm: memory-access pipeline stage.
// Issues loads/stores on a req/ack data-memory port, formats load data
// (byte/half/word, sign/zero extension, little-endian) and owns the MM/WB
// pipeline register. Stalls upstream while an access is outstanding.
// Optional feature macro: MM_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of forcing them aligned).
module stage_mm #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_flush,
    input  logic                  in_reg_wr,
    input  logic [REG_ADDR_W-1:0] in_reg_addr_rd,
    input  logic [DATA_W-1:0]     in_alu_res,
    input  logic                  in_mem_rd,
    input  logic                  in_mem_wr,
    input  logic [1:0]            in_mem_size,
    input  logic                  in_mem_unsigned,
    input  logic [DATA_W-1:0]     in_mem_wdata,
    output logic                  stall_out,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  wb_flush,
    output logic                  wb_reg_wr,
    output logic [REG_ADDR_W-1:0] wb_reg_addr_rd,
    output logic [DATA_W-1:0]     wb_alu_res,
    output logic                  misalign,
    output logic [ADDR_W-1:0]     misalign_addr
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic                  wb_flush_q, wb_flush_d;
    logic                  wb_reg_wr_q, wb_reg_wr_d;
    logic [REG_ADDR_W-1:0] wb_reg_addr_rd_q, wb_reg_addr_rd_d;
    logic [DATA_W-1:0]     wb_alu_res_q, wb_alu_res_d;

    logic                  mem_op;
    logic                  misaligned;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     rdata_byte_sh;
    logic [DATA_W-1:0]     rdata_half_sh;
    logic [DATA_W-1:0]     load_data;

    // Memory request, byte lanes, store replication and load formatting
    always_comb begin
        addr   = ADDR_W'(in_alu_res);
        mem_op = in_valid & ~in_flush & (in_mem_rd | in_mem_wr);

`ifdef MM_MISALIGN_TRAP_EN
        misaligned = (state_q == S_IDLE) & mem_op &
                     (((in_mem_size == 2'b01) & addr[0]) |
                      (in_mem_size[1] & (addr[1:0] != 2'b00)));
`else
        misaligned = 1'b0;
`endif

        // In WAIT the EX/MM register is held, so addr/be/wdata stay stable
        dmem_req   = (state_q == S_WAIT) | (mem_op & ~misaligned);
        stall_out  = dmem_req & ~dmem_ack;
        dmem_we    = dmem_req & in_mem_wr;
        dmem_addr  = {addr[ADDR_W-1:2], 2'b00};

        dmem_be    = 4'b1111;
        dmem_wdata = in_mem_wdata;
        case (in_mem_size)
            2'b00: begin
                dmem_be    = 4'(4'b0001 << addr[1:0]);
                dmem_wdata = DATA_W'({4{in_mem_wdata[7:0]}});
            end
            2'b01: begin
                dmem_be    = addr[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = DATA_W'({2{in_mem_wdata[15:0]}});
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = in_mem_wdata;
            end
        endcase

        rdata_byte_sh = dmem_rdata >> {addr[1:0], 3'b000};
        rdata_half_sh = dmem_rdata >> {addr[1], 4'b0000};
        case (in_mem_size)
            2'b00:   load_data = {{(DATA_W-8){~in_mem_unsigned & rdata_byte_sh[7]}},
                                  rdata_byte_sh[7:0]};
            2'b01:   load_data = {{(DATA_W-16){~in_mem_unsigned & rdata_half_sh[15]}},
                                  rdata_half_sh[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // Next state for the access FSM and the MM/WB register
    always_comb begin
        state_d          = state_q;
        wb_flush_d       = wb_flush_q;
        wb_reg_wr_d      = wb_reg_wr_q;
        wb_reg_addr_rd_d = wb_reg_addr_rd_q;
        wb_alu_res_d     = wb_alu_res_q;

        case (state_q)
            S_IDLE:  if (dmem_req & ~dmem_ack) state_d = S_WAIT;
            S_WAIT:  if (dmem_ack)             state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (stall_out) begin
            wb_reg_wr_d = 1'b0;
            wb_flush_d  = 1'b0;
        end else begin
            wb_reg_wr_d      = in_valid & in_reg_wr & ~in_flush & ~misaligned;
            wb_flush_d       = in_valid & in_flush;
            wb_reg_addr_rd_d = in_reg_addr_rd;
            wb_alu_res_d     = in_mem_rd ? load_data : in_alu_res;
        end
    end

`ifdef MM_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;

    // One-cycle trap pulse with the faulting address
    always_comb begin
        misalign_d      = misaligned;
        misalign_addr_d = misaligned ? addr : misalign_addr_q;
    end

    // Trap registers
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;
`else
    assign misalign      = 1'b0;
    assign misalign_addr = '0;
`endif

    // FSM state and MM/WB pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            wb_flush_q       <= 1'b0;
            wb_reg_wr_q      <= 1'b0;
            wb_reg_addr_rd_q <= '0;
            wb_alu_res_q     <= '0;
        end else begin
            state_q          <= state_d;
            wb_flush_q       <= wb_flush_d;
            wb_reg_wr_q      <= wb_reg_wr_d;
            wb_reg_addr_rd_q <= wb_reg_addr_rd_d;
            wb_alu_res_q     <= wb_alu_res_d;
        end
    end

    assign wb_flush       = wb_flush_q;
    assign wb_reg_wr      = wb_reg_wr_q;
    assign wb_reg_addr_rd = wb_reg_addr_rd_q;
    assign wb_alu_res     = wb_alu_res_q;

endmodule

// File: tb/tb_stage_mm.sv
// Self-checking bench for stage_mm: scoreboard of expected MM/WB contents,
// pushed when an op is driven and popped when the op completes.
// Build with MM_MISALIGN_TRAP_EN defined to exercise the trap variant.
module tb_stage_mm;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_flush, in_reg_wr;
    logic [4:0]  in_reg_addr_rd;
    logic [31:0] in_alu_res;
    logic        in_mem_rd, in_mem_wr;
    logic [1:0]  in_mem_size;
    logic        in_mem_unsigned;
    logic [31:0] in_mem_wdata;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_flush, wb_reg_wr;
    logic [4:0]  wb_reg_addr_rd;
    logic [31:0] wb_alu_res;
    logic        misalign;
    logic [31:0] misalign_addr;

    typedef struct packed {
        logic        reg_wr;
        logic        flush;
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    stage_mm dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_flush(in_flush), .in_reg_wr(in_reg_wr),
        .in_reg_addr_rd(in_reg_addr_rd), .in_alu_res(in_alu_res),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_mem_size(in_mem_size),
        .in_mem_unsigned(in_mem_unsigned), .in_mem_wdata(in_mem_wdata),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_flush(wb_flush), .wb_reg_wr(wb_reg_wr), .wb_reg_addr_rd(wb_reg_addr_rd),
        .wb_alu_res(wb_alu_res), .misalign(misalign), .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
        case (size)
            2'b00: case (a[1:0])
                       2'd0: return 4'b0001;
                       2'd1: return 4'b0010;
                       2'd2: return 4'b0100;
                       default: return 4'b1000;
                   endcase
            2'b01: return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'b01:   return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; in_flush = 1'b0; in_reg_wr = 1'b0; in_reg_addr_rd = '0;
        in_alu_res = '0; in_mem_rd = 1'b0; in_mem_wr = 1'b0; in_mem_size = 2'b00;
        in_mem_unsigned = 1'b0; in_mem_wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one op, model the memory with a fixed ack delay, check the bus
    // every cycle and the MM/WB register on completion.
    task automatic run_op(input string tag, input logic is_ld, input logic is_st,
                          input logic [1:0] size, input logic uns, input logic reg_wr,
                          input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int delay, input int flush_at, input logic [31:0] exp_res);
        logic mem;
        int   stalls;
        exp_t e, got;
        mem = is_ld | is_st;
        in_valid = 1'b1; in_flush = 1'b0; in_reg_wr = reg_wr; in_reg_addr_rd = rd;
        in_alu_res = alu; in_mem_rd = is_ld; in_mem_wr = is_st; in_mem_size = size;
        in_mem_unsigned = uns; in_mem_wdata = wdata;
        dmem_rdata = rdata; dmem_ack = mem && (delay == 0);
        e.reg_wr = reg_wr && (flush_at < 0);
        e.flush  = 1'b0;
        e.rd     = rd;
        e.res    = is_ld ? exp_res : alu;
        sb_q.push_back(e);
        stalls = 0;
        for (int k = 0; k <= delay; k++) begin
            if (k == flush_at) in_flush = 1'b1;
            @(negedge clk);
            check_eq({tag, "_req"}, 32'(dmem_req), 32'(mem));
            check_eq({tag, "_stall"}, 32'(stall_out), 32'(mem && (k < delay)));
            if (mem) begin
                check_eq({tag, "_addr"}, dmem_addr, {alu[31:2], 2'b00});
                check_eq({tag, "_we"}, 32'(dmem_we), 32'(is_st));
                check_eq({tag, "_be"}, 32'(dmem_be), 32'(model_be(size, alu)));
                if (is_st) check_eq({tag, "_wdata"}, dmem_wdata, model_wdata(size, wdata));
            end
            if (k > 0) check_eq({tag, "_bubble"}, 32'(wb_reg_wr), 32'd0);
            if (stall_out) stalls++;
            tick();
            if (!mem || k >= delay) break;
            dmem_ack = (k + 1 == delay);
        end
        check_eq({tag, "_nstall"}, 32'(stalls), mem ? 32'(delay) : 32'd0);
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = '{reg_wr: wb_reg_wr, flush: (flush_at < 0) ? wb_flush : 1'b0,
                    rd: wb_reg_addr_rd, res: wb_alu_res};
            e = sb_q.pop_front();
            check_eq({tag, "_wb_reg_wr"}, 32'(got.reg_wr), 32'(e.reg_wr));
            check_eq({tag, "_wb_flush"}, 32'(got.flush), 32'(e.flush));
            check_eq({tag, "_wb_rd"}, 32'(got.rd), 32'(e.rd));
            check_eq({tag, "_wb_res"}, got.res, e.res);
        end
        check_eq({tag, "_misalign"}, 32'(misalign), 32'd0);
        idle_inputs();
        @(negedge clk);
        check_eq({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        check_eq("rst_wb_flush", 32'(wb_flush), 32'd0);
        check_eq("rst_wb_rd", 32'(wb_reg_addr_rd), 32'd0);
        check_eq("rst_wb_res", wb_alu_res, 32'd0);
        check_eq("rst_misalign", 32'(misalign), 32'd0);
        check_eq("rst_misalign_addr", misalign_addr, 32'd0);
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        tick();

        //        tag      ld    st    size   uns   rw    rd  alu           wdata         rdata         dly fl  exp
        run_op("alu",    1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5,  32'h0000_1234, 32'h0,        32'h0,        0, -1, 32'h0);
        run_op("lb_s",   1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 3,  32'h0000_0103, 32'h0,        32'h80FF_0000, 3, -1, 32'hFFFF_FF80);
        run_op("sh",     1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 0,  32'h0000_0202, 32'h0000_BEEF, 32'h0,        0, -1, 32'h0);
        run_op("lbu",    1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 4,  32'h0000_0101, 32'h0,        32'h1234_80FF, 1, -1, 32'h0000_0080);
        run_op("lb_pos", 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 6,  32'h0000_0100, 32'h0,        32'h0000_007F, 0, -1, 32'h0000_007F);
        run_op("lh_s",   1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8,  32'h0000_0102, 32'h0,        32'h8001_1234, 2, -1, 32'hFFFF_8001);
        run_op("lhu",    1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 9,  32'h0000_0102, 32'h0,        32'h8001_1234, 0, -1, 32'h0000_8001);
        run_op("lh_lo",  1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 10, 32'h0000_0100, 32'h0,        32'h8001_1234, 1, -1, 32'h0000_1234);
        run_op("lw_u",   1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 11, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 1, -1, 32'hDEAD_BEEF);
        run_op("sb",     1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 0,  32'h0000_0303, 32'h0000_00A5, 32'h0,        2, -1, 32'h0);
        run_op("sw",     1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 0,  32'h0000_0400, 32'h0102_0304, 32'h0,        1, -1, 32'h0);
        run_op("alu2",   1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12, 32'hA5A5_0001, 32'h0,        32'h0,        0, -1, 32'h0);
        run_op("lw_fl",  1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 7,  32'h0000_0500, 32'h0,        32'h1111_2222, 3,  1, 32'h1111_2222);
`ifndef MM_MISALIGN_TRAP_EN
        run_op("lw_mis", 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 13, 32'h0000_0107, 32'h0,        32'hCAFE_F00D, 1, -1, 32'hCAFE_F00D);
        run_op("lh_mis", 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 14, 32'h0000_0103, 32'h0,        32'hF123_4567, 0, -1, 32'hFFFF_F123);
`endif

        // Flushed non-memory op: squash marker, no write
        in_valid = 1'b1; in_flush = 1'b1; in_reg_wr = 1'b1; in_reg_addr_rd = 5'd15;
        in_alu_res = 32'h0000_0777;
        @(negedge clk);
        check_eq("fl_alu_stall", 32'(stall_out), 32'd0);
        tick();
        check_eq("fl_alu_wb_flush", 32'(wb_flush), 32'd1);
        check_eq("fl_alu_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        idle_inputs();

        // Flushed load in IDLE never reaches the bus
        in_valid = 1'b1; in_flush = 1'b1; in_reg_wr = 1'b1; in_reg_addr_rd = 5'd16;
        in_alu_res = 32'h0000_0800; in_mem_rd = 1'b1; in_mem_size = 2'b10;
        @(negedge clk);
        check_eq("fl_ld_req", 32'(dmem_req), 32'd0);
        check_eq("fl_ld_stall", 32'(stall_out), 32'd0);
        tick();
        check_eq("fl_ld_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        idle_inputs();
        tick();

`ifdef MM_MISALIGN_TRAP_EN
        // Misaligned word load traps instead of accessing memory
        in_valid = 1'b1; in_reg_wr = 1'b1; in_reg_addr_rd = 5'd17;
        in_alu_res = 32'h0000_0101; in_mem_rd = 1'b1; in_mem_size = 2'b10;
        @(negedge clk);
        check_eq("trap_req", 32'(dmem_req), 32'd0);
        check_eq("trap_stall", 32'(stall_out), 32'd0);
        tick();
        check_eq("trap_misalign", 32'(misalign), 32'd1);
        check_eq("trap_addr", misalign_addr, 32'h0000_0101);
        check_eq("trap_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        idle_inputs();
        tick();
        check_eq("trap_pulse_end", 32'(misalign), 32'd0);
`endif

        // Reset while an access is outstanding abandons it
        in_valid = 1'b1; in_reg_wr = 1'b1; in_reg_addr_rd = 5'd18;
        in_alu_res = 32'h0000_0600; in_mem_rd = 1'b1; in_mem_size = 2'b10;
        @(negedge clk);
        check_eq("rw_req0", 32'(dmem_req), 32'd1);
        tick();
        @(negedge clk);
        check_eq("rw_stall_wait", 32'(stall_out), 32'd1);
        tick();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rw_req", 32'(dmem_req), 32'd0);
        check_eq("rw_stall", 32'(stall_out), 32'd0);
        check_eq("rw_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        check_eq("rw_wb_res", wb_alu_res, 32'd0);
        tick();

        // Back to normal operation after the abandoned access
        run_op("post_rst", 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 19, 32'h0000_0700, 32'h0, 32'h5555_AAAA, 1, -1, 32'h5555_AAAA);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
